// File: rtl/hci_mem_rmw_adapter_pkg.sv
// Shared types for the HCI bank read-modify-write adapter.
package hci_mem_rmw_adapter_pkg;

  // IDLE passes accesses through; MERGE writes back a merged partial word.
  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } hci_rmw_state_e;

endpackage

// File: rtl/hci_mem_rmw_adapter.sv
// Per-bank adapter between an HCI bank port and a word-only SRAM.
// Full-word accesses pass straight through; partial writes become a
// read followed by a merged full-word write, stalling the bank one cycle.
module hci_mem_rmw_adapter
  import hci_mem_rmw_adapter_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BW    = 8,
  parameter int UW    = 0,
  parameter int CNT_W = 16,
  localparam int NB   = DW / BW,
  localparam int UWP  = (UW > 0) ? UW : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                tgt_req,
  input  logic [AW-1:0]       tgt_add,
  input  logic                tgt_wen,
  input  logic [DW-1:0]       tgt_data,
  input  logic [NB-1:0]       tgt_be,
  input  logic [UWP-1:0]      tgt_user,
  output logic                tgt_gnt,
  output logic [DW-1:0]       tgt_r_data,
  output logic [UWP-1:0]      tgt_r_user,
  output logic                tgt_r_valid,
  output logic                sram_req_o,
  output logic                sram_wen_o,
  output logic [AW-3:0]       sram_add_o,
  output logic [DW+UW-1:0]    sram_wdata_o,
  input  logic [DW+UW-1:0]    sram_rdata_i,
  output logic [CNT_W-1:0]    rmw_cnt_o
);

  hci_rmw_state_e state, state_next;

  logic [AW-3:0]    lat_add;
  logic [DW-1:0]    lat_data;
  logic [NB-1:0]    lat_be;
  logic [UWP-1:0]   lat_user;

  logic             is_partial;
  logic             grant;
  logic             partial_grant;
  logic [DW-1:0]    merged_data;
  logic [DW+UW-1:0] merged_word;
  logic [DW+UW-1:0] direct_word;
  logic             unused_bits;

  assign is_partial = ~tgt_wen & ~(&tgt_be);

  // Lane merge: enabled lanes take the latched write data, others keep SRAM content.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign merged_data[i*BW +: BW] = lat_be[i] ? lat_data[i*BW +: BW]
                                               : sram_rdata_i[i*BW +: BW];
  end

  // User bits ride as an always-written extra lane when present.
  if (UW > 0) begin : g_user
    assign merged_word = {lat_user, merged_data};
    assign direct_word = {tgt_user, tgt_data};
    assign tgt_r_user  = sram_rdata_i[DW +: UWP];
  end else begin : g_nouser
    assign merged_word = merged_data;
    assign direct_word = tgt_data;
    assign tgt_r_user  = '0;
  end

  assign tgt_r_data  = sram_rdata_i[DW-1:0];
  assign unused_bits = ^{tgt_add[1:0], tgt_user, lat_user};

  // Next-state and SRAM/grant steering for pass-through and merge write-back.
  always_comb begin
    state_next    = state;
    tgt_gnt       = 1'b0;
    sram_req_o    = 1'b0;
    sram_wen_o    = 1'b1;
    sram_add_o    = tgt_add[AW-1:2];
    sram_wdata_o  = direct_word;
    grant         = 1'b0;
    partial_grant = 1'b0;
    case (state)
      IDLE: begin
        if (tgt_req) begin
          tgt_gnt    = 1'b1;
          sram_req_o = 1'b1;
          grant      = 1'b1;
          if (is_partial) begin
            sram_wen_o    = 1'b1;
            partial_grant = 1'b1;
            state_next    = MERGE;
          end else begin
            sram_wen_o = tgt_wen;
          end
        end
      end
      MERGE: begin
        sram_req_o   = ~clear_i;
        sram_wen_o   = 1'b0;
        sram_add_o   = lat_add;
        sram_wdata_o = merged_word;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear_i) begin
      state_next = IDLE;
    end
  end

  // State, response-valid, latch and saturating counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      tgt_r_valid <= 1'b0;
      rmw_cnt_o   <= '0;
      lat_add     <= '0;
      lat_data    <= '0;
      lat_be      <= '0;
      lat_user    <= '0;
    end else if (clear_i) begin
      state       <= IDLE;
      tgt_r_valid <= 1'b0;
      rmw_cnt_o   <= '0;
    end else begin
      state       <= state_next;
      tgt_r_valid <= grant;
      if (partial_grant) begin
        lat_add  <= tgt_add[AW-1:2];
        lat_data <= tgt_data;
        lat_be   <= tgt_be;
        lat_user <= tgt_user;
        if (rmw_cnt_o != {CNT_W{1'b1}}) begin
          rmw_cnt_o <= rmw_cnt_o + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hci_mem_rmw_adapter.sv
// Scoreboard bench for hci_mem_rmw_adapter with a word-only SRAM model.
module tb_hci_mem_rmw_adapter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int UW    = 0;
  localparam int CNT_W = 3;
  localparam int NB    = DW / BW;
  localparam int WORDS = 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             tgt_req;
  logic [AW-1:0]    tgt_add;
  logic             tgt_wen;
  logic [DW-1:0]    tgt_data;
  logic [NB-1:0]    tgt_be;
  logic [0:0]       tgt_user;
  logic             tgt_gnt;
  logic [DW-1:0]    tgt_r_data;
  logic [0:0]       tgt_r_user;
  logic             tgt_r_valid;
  logic             sram_req;
  logic             sram_wen;
  logic [AW-3:0]    sram_add;
  logic [DW+UW-1:0] sram_wdata;
  logic [DW+UW-1:0] sram_rdata;
  logic [CNT_W-1:0] rmw_cnt;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          tests;
  int          fails;
  int          cyc;
  bit          mon_en;
  int          cnt_model;
  logic [31:0] ref_mem[WORDS];
  logic [31:0] sram_mem[WORDS];

  hci_mem_rmw_adapter #(
    .AW(AW), .DW(DW), .BW(BW), .UW(UW), .CNT_W(CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .tgt_req      (tgt_req),
    .tgt_add      (tgt_add),
    .tgt_wen      (tgt_wen),
    .tgt_data     (tgt_data),
    .tgt_be       (tgt_be),
    .tgt_user     (tgt_user),
    .tgt_gnt      (tgt_gnt),
    .tgt_r_data   (tgt_r_data),
    .tgt_r_user   (tgt_r_user),
    .tgt_r_valid  (tgt_r_valid),
    .sram_req_o   (sram_req),
    .sram_wen_o   (sram_wen),
    .sram_add_o   (sram_add),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata),
    .rmw_cnt_o    (rmw_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word-only SRAM: registered read data, full-word writes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_rdata <= '0;
      for (int i = 0; i < WORDS; i++) sram_mem[i] <= 32'(i) * 32'h9E3779B9;
    end else if (sram_req) begin
      if (!sram_wen) sram_mem[sram_add[4:0]] <= sram_wdata;
      else           sram_rdata <= sram_mem[sram_add[4:0]];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every r_valid pops the oldest granted access and checks it.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tgt_r_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL spurious_r_valid: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("r_valid_latency", 32'(cyc), 32'(e.cyc + 1));
          if (e.is_read) checkOutput("read_data", tgt_r_data, e.data);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        void'(sbq.pop_front());
        tests++;
        fails++;
        $display("[TB] FAIL missing_r_valid: got 0, expected 1 (cycle %0d)", cyc);
      end
    end
  end

  task automatic waitGrant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tgt_gnt === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    tests++;
    fails++;
    $display("[TB] FAIL grant_timeout: got no gnt, expected gnt within 8 cycles");
  endtask

  // Issue one access; partial writes optionally hold a read behind them
  // and optionally pulse clear during the merge cycle.
  task automatic applyStimulus(input logic wen, input logic [4:0] widx,
                               input logic [31:0] data, input logic [3:0] be,
                               input bit follow_read, input bit clear_merge);
    bit          ok;
    bit          partial;
    exp_t        e;
    logic [31:0] expw;
    int          gcyc;
    tgt_req  = 1'b1;
    tgt_wen  = wen;
    tgt_add  = {25'd0, widx, 2'b00};
    tgt_data = data;
    tgt_be   = be;
    waitGrant(ok);
    if (!ok) begin
      tgt_req = 1'b0;
      return;
    end
    partial   = !wen && (be != 4'hF);
    e.is_read = wen;
    e.data    = ref_mem[widx];
    e.cyc     = cyc;
    gcyc      = cyc;
    sbq.push_back(e);
    if (!partial) begin
      if (!wen) ref_mem[widx] = data;
      @(posedge clk); #1;
      tgt_req = 1'b0;
    end else begin
      expw = merge(ref_mem[widx], data, be);
      if (cnt_model < CNT_MAX) cnt_model++;
      @(posedge clk); #1;
      clear = clear_merge;
      if (follow_read) tgt_wen = 1'b1;
      else             tgt_req = 1'b0;
      @(negedge clk);
      checkOutput("merge_gnt", 32'(tgt_gnt), 32'd0);
      checkOutput("merge_sram_req", 32'(sram_req), 32'(!clear_merge));
      if (!clear_merge) begin
        checkOutput("merge_sram_wen", 32'(sram_wen), 32'd0);
        checkOutput("merge_sram_add", 32'(sram_add), 32'(widx));
        checkOutput("merge_wdata", sram_wdata, expw);
        ref_mem[widx] = expw;
      end else begin
        cnt_model = 0;
      end
      @(posedge clk); #1;
      clear = 1'b0;
      if (follow_read) begin
        waitGrant(ok);
        if (ok) begin
          checkOutput("b2b_grant_cycle", 32'(cyc), 32'(gcyc + 2));
          e.is_read = 1'b1;
          e.data    = ref_mem[widx];
          e.cyc     = cyc;
          sbq.push_back(e);
        end
        @(posedge clk); #1;
        tgt_req = 1'b0;
      end
    end
    checkOutput("rmw_cnt", 32'(rmw_cnt), 32'(cnt_model));
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    mon_en    = 1'b0;
    cnt_model = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    tgt_req   = 1'b0;
    tgt_wen   = 1'b1;
    tgt_add   = '0;
    tgt_data  = '0;
    tgt_be    = '0;
    tgt_user  = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'(i) * 32'h9E3779B9;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_r_valid", 32'(tgt_r_valid), 32'd0);
    checkOutput("reset_rmw_cnt", 32'(rmw_cnt), 32'd0);
    tgt_req = 1'b1;
    #1;
    checkOutput("reset_gnt_follows_req", 32'(tgt_gnt), 32'd1);
    checkOutput("reset_sram_req_follows_req", 32'(sram_req), 32'd1);
    tgt_req = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b0, 5'd16, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd16, 32'h0,        4'hF, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd3,  32'h11223344, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd3,  32'hAABBCCDD, 4'h5, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd4,  32'h12345678, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd5,  32'hCAFEF00D, 4'h3, 1'b1, 1'b1);

    for (int i = 0; i < 9; i++)
      applyStimulus(1'b0, 5'($urandom_range(0, WORDS - 1)), $urandom,
                    4'($urandom_range(0, 14)), 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic       w;
      logic [3:0] b;
      w = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      applyStimulus(w, 5'($urandom_range(0, WORDS - 1)), $urandom, b,
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
